// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner: double-buffered hex 7-seg scan driver; outputs registered, 1 cycle after scan state.
// No backpressure (load always accepted). Option macro SEVEN_SEG_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seven_segment_scanner #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000,
  parameter int DIV_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [6:0]            seg_out,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     an_out,
  output logic                  frame_tick
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

  logic [DIV_W-1:0]    presc;
  logic [IDX_W-1:0]    idx;
  logic [4*DIGITS-1:0] pend_dat;
  logic [DIGITS-1:0]   pend_dp;
  logic                pend_vld;
  logic [4*DIGITS-1:0] disp_dat;
  logic [DIGITS-1:0]   disp_dp;

  logic                boundary;
  logic [DIGITS-1:0]   blank_mask;
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_blank;
  logic [6:0]          seg_lit;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign boundary = enable && (idx == IDX_LAST) && (presc == PRESC_LAST);

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  // Walk down from the most significant digit; digit 0 always stays visible.
  logic lead_zero;
  always_comb begin
    lead_zero  = 1'b1;
    blank_mask = '0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      lead_zero     = lead_zero & (disp_dat[4*k +: 4] == 4'h0);
      blank_mask[k] = lead_zero;
    end
  end
`else
  assign blank_mask = '0;
`endif

  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        cur_nib   = disp_dat[4*k +: 4];
        cur_dp    = disp_dp[k];
        cur_blank = blank_mask[k];
      end
    end
  end

  assign seg_lit = cur_blank ? 7'h7F : decode(cur_nib);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc      <= '0;
      idx        <= '0;
      pend_dat   <= '0;
      pend_dp    <= '0;
      pend_vld   <= 1'b0;
      disp_dat   <= '0;
      disp_dp    <= '0;
      seg_out    <= 7'h7F;
      dp_out     <= 1'b1;
      an_out     <= '1;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= boundary;

      if (!enable) begin
        presc <= '0;
        idx   <= '0;
      end else if (presc == PRESC_LAST) begin
        presc <= '0;
        idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end

      // While stopped there is no frame to tear, so loads land directly.
      if (!enable) begin
        if (load) begin
          disp_dat <= data_in;
          disp_dp  <= dp_in;
          pend_vld <= 1'b0;
        end
      end else if (boundary) begin
        if (load) begin
          disp_dat <= data_in;
          disp_dp  <= dp_in;
        end else if (pend_vld) begin
          disp_dat <= pend_dat;
          disp_dp  <= pend_dp;
        end
        pend_vld <= 1'b0;
      end else if (load) begin
        pend_dat <= data_in;
        pend_dp  <= dp_in;
        pend_vld <= 1'b1;
      end

      // First cycle of each slot is dark to stop the previous digit ghosting.
      if (!enable || presc == '0) begin
        an_out  <= '1;
        seg_out <= 7'h7F;
        dp_out  <= 1'b1;
      end else begin
        an_out  <= ~(DIGITS'(1) << idx);
        seg_out <= seg_lit;
        dp_out  <= ~cur_dp;
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Bench for seven_segment_scanner (DIGITS=4, SCAN_DIV=4): directed checks plus a per-frame slot scoreboard.
module tb_seven_segment_scanner;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;
  localparam int DIV_W    = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0]  dp_in = '0;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  an_out;
  logic        frame_tick;

  seven_segment_scanner #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load),
    .data_in(data_in), .dp_in(dp_in),
    .seg_out(seg_out), .dp_out(dp_out), .an_out(an_out), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    string      tag;
  } slot_t;

  slot_t exp_q[$];

  function automatic logic [6:0] seg_of(input logic [3:0] nib);
    logic [6:0] tbl [16];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return tbl[nib];
  endfunction

  // Expected slots for one frame, digit 0 first (scan order).
  task automatic push_frame(input logic [15:0] d, input logic [3:0] dp, input string tag);
    logic [6:0] segs [4];
    logic       lead;
    logic [3:0] nib;
    slot_t      s;
    lead = 1'b1;
    for (int k = 3; k >= 0; k--) begin
      nib = d[4*k +: 4];
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
      if (k != 0 && lead && nib == 4'h0) segs[k] = 7'h7F;
      else begin
        lead    = 1'b0;
        segs[k] = seg_of(nib);
      end
`else
      segs[k] = seg_of(nib);
`endif
    end
    for (int k = 0; k < 4; k++) begin
      s.an  = ~(4'b0001 << k);
      s.seg = segs[k];
      s.dp  = ~dp[k];
      s.tag = $sformatf("%s_d%0d", tag, k);
      exp_q.push_back(s);
    end
  endtask

  // Compare on the first lit cycle of each digit slot.
  logic prev_blank = 1'b1;
  always @(negedge clk) begin
    slot_t e;
    if (an_out != 4'hF && prev_blank && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({e.tag, "_an"},  32'(an_out),  32'(e.an));
      check({e.tag, "_seg"}, 32'(seg_out), 32'(e.seg));
      check({e.tag, "_dp"},  32'(dp_out),  32'(e.dp));
    end
    prev_blank = (an_out == 4'hF);
  end

  task automatic wait_tick(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_tick !== 1'b1 && n < 100);
    if (frame_tick !== 1'b1) check({tag, "_tick_timeout"}, 0, 1);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      check({tag, "_drain_timeout"}, 32'(exp_q.size()), 0);
      exp_q.delete();
    end
  endtask

  task automatic pulse_load(input logic [15:0] d, input logic [3:0] dp);
    data_in = d;
    dp_in   = dp;
    load    = 1'b1;
    @(negedge clk);
    load    = 1'b0;
  endtask

  initial begin
    int n;
    // Reset held three cycles with enable already high.
    enable = 1'b1;
    @(posedge clk);
    repeat (3) begin
      @(negedge clk);
      check("reset_outs", {frame_tick, dp_out, an_out, seg_out}, {1'b0, 1'b1, 4'hF, 7'h7F});
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_blank", {an_out, seg_out}, {4'hF, 7'h7F});
    repeat (3) begin
      @(negedge clk);
      check("post_rst_d0", {dp_out, an_out, seg_out}, {1'b1, 4'hE, 7'h40});
    end

    // Mid-frame load must not show until the next frame boundary.
    pulse_load(16'h1A3F, 4'b0010);
    n = 0;
    while (frame_tick !== 1'b1 && n < 100) begin
      if (an_out != 4'hF) check("hold_old_seg", 32'(seg_out), 32'h40);
      @(negedge clk);
      n++;
    end
    check("tick_after_load", 32'(frame_tick), 1);
    push_frame(16'h1A3F, 4'b0010, "f1a3f");
    drain("f1a3f");

    // Two loads in one frame: last one wins.
    wait_tick("two_loads");
    pulse_load(16'h1111, 4'b0000);
    repeat (2) @(negedge clk);
    pulse_load(16'h2222, 4'b0000);
    wait_tick("two_loads_b");
    push_frame(16'h2222, 4'b0000, "f2222");
    drain("f2222");

    // Load exactly on the boundary cycle commits directly.
    wait_tick("bnd");
    repeat (15) @(negedge clk);
    data_in = 16'h8888;
    dp_in   = 4'b0000;
    load    = 1'b1;
    @(negedge clk);
    load    = 1'b0;
    check("bnd_tick", 32'(frame_tick), 1);
    push_frame(16'h8888, 4'b0000, "f8888");
    drain("f8888");

    // Disable mid-frame, load while stopped, restart.
    wait_tick("dis");
    repeat (5) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("dis_an", 32'(an_out), 32'hF);
    check("dis_tick", 32'(frame_tick), 0);
    pulse_load(16'h0005, 4'b0000);
    repeat (3) begin
      @(negedge clk);
      check("dis_blank", {frame_tick, an_out, seg_out}, {1'b0, 4'hF, 7'h7F});
    end
    enable = 1'b1;
    push_frame(16'h0005, 4'b0000, "f0005");
    drain("f0005");

    // Leading zeros (blanked only when the option is built in).
    wait_tick("lz");
    pulse_load(16'h0050, 4'b0001);
    wait_tick("lz_b");
    push_frame(16'h0050, 4'b0001, "f0050");
    drain("f0050");

    // Reset mid-frame discards pending data and clears the display buffer.
    wait_tick("mrst");
    repeat (3) @(negedge clk);
    pulse_load(16'h7777, 4'b1111);
    rst_n = 1'b0;
    @(negedge clk);
    check("mrst_outs", {frame_tick, dp_out, an_out, seg_out}, {1'b0, 1'b1, 4'hF, 7'h7F});
    rst_n = 1'b1;
    push_frame(16'h0000, 4'b0000, "rst_fa");
    push_frame(16'h0000, 4'b0000, "rst_fb");
    drain("mrst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
